// File: rtl/if_id_skid_buffer.sv
// if_id_skid_buffer: two-entry IF->ID skid buffer with registered in_ready and decode field split
module if_id_skid_buffer #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [15:0]       out_imm16,
  output logic              out_ext_op,
  output logic              out_adel
);
  logic              h_valid, s_valid;
  logic [PC_W-1:0]   h_pc, s_pc;
  logic [INST_W-1:0] h_inst, s_inst;
  logic              push, pop;
  logic [5:0]        opcode;
  assign push = in_valid & ~s_valid & ~flush;
  assign pop  = h_valid & out_ready & ~flush;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
      h_pc    <= '0;
      h_inst  <= '0;
      s_pc    <= '0;
      s_inst  <= '0;
    end else if (flush) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (s_valid) begin
      if (pop) begin
        h_pc    <= s_pc;
        h_inst  <= s_inst;
        s_valid <= 1'b0;
      end
    end else if (h_valid) begin
      if (push && !pop) begin
        s_pc    <= in_pc;
        s_inst  <= in_inst;
        s_valid <= 1'b1;
      end else if (push) begin
        h_pc   <= in_pc;
        h_inst <= in_inst;
      end else if (pop) begin
        h_valid <= 1'b0;
      end
    end else if (push) begin
      h_pc    <= in_pc;
      h_inst  <= in_inst;
      h_valid <= 1'b1;
    end
  // in_ready comes straight from the skid valid flop, so it never sees out_ready
  assign in_ready   = ~s_valid;
  assign out_valid  = h_valid;
  assign out_pc     = h_pc;
  assign out_inst   = h_inst;
  assign out_rs     = h_inst[25:21];
  assign out_rt     = h_inst[20:16];
  assign out_rd     = h_inst[15:11];
  assign out_shamt  = h_inst[10:6];
  assign out_imm16  = h_inst[15:0];
  assign opcode     = h_inst[31:26];
  assign out_ext_op = ~(opcode == 6'b001100 || opcode == 6'b001101 || opcode == 6'b001110);
  assign out_adel   = |h_pc[1:0];
endmodule

// File: tb/tb_if_id_skid_buffer.sv
// tb_if_id_skid_buffer: queue-model scoreboard plus directed literal checks for the IF->ID skid buffer
module tb_if_id_skid_buffer;
  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm16;
  logic        out_ext_op, out_adel;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] q[$];

  if_id_skid_buffer #(.PC_W(32), .INST_W(32)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_imm16(out_imm16), .out_ext_op(out_ext_op), .out_adel(out_adel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: the buffer is just a FIFO of at most two accepted {pc,inst} pairs
  task automatic model_update();
    bit push, pop;
    push = in_valid && q.size() < 2 && !flush;
    pop  = q.size() > 0 && out_ready && !flush;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back({in_pc, in_inst});
    end
  endtask

  task automatic cyc(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                     input logic ordy, input logic fl);
    in_valid = iv; in_pc = pc; in_inst = inst; out_ready = ordy; flush = fl;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [31:0] epc, einst;
    logic [5:0]  op;
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      {epc, einst} = q[0];
      op = einst[31:26];
      chk("out_pc", out_pc, epc);
      chk("out_inst", out_inst, einst);
      chk("out_rs", 32'(out_rs), einst >> 21 & 32'h1f);
      chk("out_rt", 32'(out_rt), einst >> 16 & 32'h1f);
      chk("out_rd", 32'(out_rd), einst >> 11 & 32'h1f);
      chk("out_shamt", 32'(out_shamt), einst >> 6 & 32'h1f);
      chk("out_imm16", 32'(out_imm16), einst & 32'hffff);
      chk("out_ext_op", 32'(out_ext_op), 32'(!(op >= 6'd12 && op <= 6'd14)));
      chk("out_adel", 32'(out_adel), 32'(epc % 4 != 0));
    end
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_ext_op", 32'(out_ext_op), 32'd1);
    resetn = 1'b1;
    // streaming: each word visible one edge after acceptance
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'hBFC00000 + 32'(i * 4), 32'h20000000 + 32'(i), 1'b1, 1'b0);
      chk("stream_pc", out_pc, 32'hBFC00000 + 32'(i * 4));
      chk("stream_valid", 32'(out_valid), 32'd1);
    end
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("stream_drain", 32'(out_valid), 32'd0);
    // backpressure into FULL
    cyc(1'b1, 32'hBFC00000, 32'h24080005, 1'b0, 1'b0);
    cyc(1'b1, 32'hBFC00004, 32'h3108FFFF, 1'b0, 1'b0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    cyc(1'b1, 32'hBFC00008, 32'h24090001, 1'b0, 1'b0);
    chk("bp_hold_pc", out_pc, 32'hBFC00000);
    chk("bp_ext_op1", 32'(out_ext_op), 32'd1);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_pc2", out_pc, 32'hBFC00004);
    chk("bp_ext_op0", 32'(out_ext_op), 32'd0);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_empty", 32'(out_valid), 32'd0);
    // flush while FULL drops everything including the word offered that cycle
    cyc(1'b1, 32'hBFC00010, 32'h11111111, 1'b0, 1'b0);
    cyc(1'b1, 32'hBFC00014, 32'h22222222, 1'b0, 1'b0);
    cyc(1'b1, 32'hBFC00018, 32'h33333333, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("flush_lost", 32'(out_valid), 32'd0);
    // field split and misaligned pc
    cyc(1'b1, 32'hBFC00002, 32'h00851040, 1'b0, 1'b0);
    chk("f_rs", 32'(out_rs), 32'd4);
    chk("f_rt", 32'(out_rt), 32'd5);
    chk("f_rd", 32'(out_rd), 32'd2);
    chk("f_shamt", 32'(out_shamt), 32'd1);
    chk("f_imm16", 32'(out_imm16), 32'h1040);
    chk("f_adel", 32'(out_adel), 32'd1);
    // async reset mid-cycle with an entry buffered
    cyc(1'b1, 32'hBFC00020, 32'h34010001, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    q.delete();
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_pc", out_pc, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    // random traffic against the FIFO model
    for (int i = 0; i < 10000; i++)
      cyc(1'b1 & ($urandom_range(3) != 0), $urandom, $urandom,
          1'b1 & ($urandom_range(1) != 0), 1'b1 & ($urandom_range(63) == 0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
